// File: rtl/jt51_kon_pkg.sv
// Shared definitions for the key-on bank.
//   - default channel / operator counts and the derived slot-index width
//   - write-sequencer state encoding
//   - kon_op_bit(): maps an operator number to its bit in the keyon_op mask
package jt51_kon_pkg;

    localparam int KON_CH_DEF     = 8;
    localparam int KON_OP_DEF     = 4;
    localparam int KON_SLOTS_DEF  = KON_CH_DEF * KON_OP_DEF;
    localparam int KON_SLOT_W_DEF = $clog2(KON_SLOTS_DEF);

    // IDLE  : nothing pending
    // WAIT  : request captured, waiting for the channel's op0 slot
    // WRITE : channel visit in progress, slots are being overwritten
    typedef enum logic [1:0] {
        KON_IDLE  = 2'd0,
        KON_WAIT  = 2'd1,
        KON_WRITE = 2'd2
    } kon_state_e;

    // The YM2151 register layout swaps operators 1 and 2 in the key-on mask
    // when four operators are in use.
    function automatic int unsigned kon_op_bit(input int unsigned op,
                                               input int unsigned nops,
                                               input int unsigned opn_order);
        int unsigned bit_idx;
        bit_idx = op;
        if (opn_order == 1 && nops == 4) begin
            if (op == 1)
                bit_idx = 2;
            else if (op == 2)
                bit_idx = 1;
        end
        return bit_idx;
    endfunction

endpackage

// File: rtl/jt51_sh.sv
// Generic clock-enabled shift register.
//   clk, rst (async, active high), cen : clocking
//   din  [WIDTH-1:0] : value entering stage 0
//   drop [WIDTH-1:0] : value leaving the last stage (STAGES cen cycles later)
module jt51_sh #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] drop
);

    logic [STAGES-1:0][WIDTH-1:0] bits_q;
    logic [STAGES-1:0][WIDTH-1:0] bits_d;

    always_comb begin
        bits_d = {bits_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bits_q <= '0;
        else if (cen)
            bits_q <= bits_d;
    end

    assign drop = bits_q[STAGES-1];

endmodule

// File: rtl/jt51_kon_bank.sv
// Key-on bank: per-slot key state storage, CSM key-on window and key edge
// detection for a slot-serial FM engine.
//   clk, rst, cen          : clocking (rst async active high)
//   keyon_op/keyon_ch      : key mask and channel of a write request
//   up_keyon               : write strobe
//   busy                   : a captured request has not finished writing
//   cur_op/cur_ch          : slot currently presented by the engine
//   csm, overflow_A        : CSM mode and timer A overflow
//   keyon_II               : effective key of the previous cen cycle's slot
//   kon_edge/koff_edge     : effective key rose / fell since that slot's last visit
//
// Request handshake: on a cen cycle, up_keyon is accepted when busy is low or
// when the pending write completes in that same cycle; otherwise it is
// dropped and the pending contents are left untouched.
module jt51_kon_bank
    import jt51_kon_pkg::*;
#(
    parameter int CH        = KON_CH_DEF,
    parameter int OP        = KON_OP_DEF,
    parameter int OPN_ORDER = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen,
    input  logic [OP-1:0]         keyon_op,
    input  logic [$clog2(CH)-1:0] keyon_ch,
    input  logic                  up_keyon,
    output logic                  busy,
    input  logic [$clog2(OP)-1:0] cur_op,
    input  logic [$clog2(CH)-1:0] cur_ch,
    input  logic                  csm,
    input  logic                  overflow_A,
    output logic                  keyon_II,
    output logic                  kon_edge,
    output logic                  koff_edge
);

    localparam int SLOTS = CH * OP;
    localparam int CHW   = $clog2(CH);
    localparam int OPW   = $clog2(OP);
    localparam int CSMW  = $clog2(SLOTS + 1);

    kon_state_e      st_q, st_d;
    logic [CHW-1:0]  pend_ch_q, pend_ch_d;
    logic [OP-1:0]   pend_op_q, pend_op_d;
    logic [CSMW-1:0] csm_cnt_q, csm_cnt_d;
    logic            keyon_ii_q, keyon_ii_d;
    logic            kon_edge_q, kon_edge_d;
    logic            koff_edge_q, koff_edge_d;

    logic            ch_hit, op_first, op_last;
    logic            wr_en, wr_done, accept;
    logic [OPW-1:0]  map_idx;
    logic            stored_out, stored_in;
    logic            hist_out, eff_key, csm_on;

    jt51_sh #(.WIDTH(1), .STAGES(SLOTS)) u_stored (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .din  (stored_in),
        .drop (stored_out)
    );

    jt51_sh #(.WIDTH(1), .STAGES(SLOTS)) u_history (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .din  (eff_key),
        .drop (hist_out)
    );

    always_comb begin
        ch_hit   = (cur_ch == pend_ch_q);
        op_first = (cur_op == '0);
        op_last  = (cur_op == OPW'(OP - 1));
        map_idx  = OPW'(kon_op_bit(32'(cur_op), OP, OPN_ORDER));
        csm_on   = (csm_cnt_q != '0);
    end

    // Write sequencer. A write only starts at op0 of the pending channel so a
    // channel is always updated as a whole visit.
    always_comb begin
        st_d      = st_q;
        pend_ch_d = pend_ch_q;
        pend_op_d = pend_op_q;
        wr_en     = 1'b0;
        wr_done   = 1'b0;
        case (st_q)
            KON_WAIT: begin
                if (ch_hit && op_first) begin
                    wr_en = 1'b1;
                    st_d  = KON_WRITE;
                end
            end
            KON_WRITE: begin
                if (ch_hit) begin
                    wr_en = 1'b1;
                    if (op_last) begin
                        wr_done = 1'b1;
                        st_d    = KON_IDLE;
                    end
                end
            end
            default: begin
            end
        endcase
        accept = up_keyon && ((st_q == KON_IDLE) || wr_done);
        if (accept) begin
            pend_ch_d = keyon_ch;
            pend_op_d = keyon_op;
            st_d      = KON_WAIT;
        end
    end

    // Stored state is the pre-write value, so a write shows on the next visit.
    always_comb begin
        stored_in = wr_en ? pend_op_q[map_idx] : stored_out;
        eff_key   = stored_out | csm_on;

        csm_cnt_d = csm_cnt_q;
        if (overflow_A && csm)
            csm_cnt_d = CSMW'(SLOTS);
        else if (csm_on)
            csm_cnt_d = csm_cnt_q - 1'b1;

        keyon_ii_d  = eff_key;
        kon_edge_d  = eff_key & ~hist_out;
        koff_edge_d = ~eff_key & hist_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= KON_IDLE;
            pend_ch_q   <= '0;
            pend_op_q   <= '0;
            csm_cnt_q   <= '0;
            keyon_ii_q  <= 1'b0;
            kon_edge_q  <= 1'b0;
            koff_edge_q <= 1'b0;
        end else if (cen) begin
            st_q        <= st_d;
            pend_ch_q   <= pend_ch_d;
            pend_op_q   <= pend_op_d;
            csm_cnt_q   <= csm_cnt_d;
            keyon_ii_q  <= keyon_ii_d;
            kon_edge_q  <= kon_edge_d;
            koff_edge_q <= koff_edge_d;
        end
    end

    assign busy      = (st_q != KON_IDLE);
    assign keyon_II  = keyon_ii_q;
    assign kon_edge  = kon_edge_q;
    assign koff_edge = koff_edge_q;

endmodule

// File: tb/tb_jt51_kon_bank.sv
module tb_jt51_kon_bank;

    localparam int CH    = 8;
    localparam int OP    = 4;
    localparam int SLOTS = CH * OP;

    logic       clk = 1'b0;
    logic       rst, cen, up_keyon, csm, overflow_A;
    logic [3:0] keyon_op;
    logic [2:0] keyon_ch, cur_ch;
    logic [1:0] cur_op;
    logic       busy, keyon_II, kon_edge, koff_edge;

    always #5 clk = ~clk;

    jt51_kon_bank #(.CH(CH), .OP(OP), .OPN_ORDER(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .keyon_op   (keyon_op),
        .keyon_ch   (keyon_ch),
        .up_keyon   (up_keyon),
        .busy       (busy),
        .cur_op     (cur_op),
        .cur_ch     (cur_ch),
        .csm        (csm),
        .overflow_A (overflow_A),
        .keyon_II   (keyon_II),
        .kon_edge   (kon_edge),
        .koff_edge  (koff_edge)
    );

    int compared   = 0;
    int mismatched = 0;

    // scoreboard: {keyon_II, kon_edge, koff_edge}
    logic [2:0] exp_q[$];
    logic [2:0] last_exp;

    // reference state: intended key per slot, previous effective key per slot
    logic intent[SLOTS];
    logic prev[SLOTS];
    int   csm_left;
    int   slot_idx;
    int   rot;
    int   busy_cnt;
    bit   cen_stretch;
    bit   sched_valid;
    int   sched_rot;
    int   sched_ch;
    logic [3:0] sched_mask;
    int   op_map[4] = '{0, 2, 1, 3};

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            intent[i] = 1'b0;
            prev[i]   = 1'b0;
        end
        csm_left    = 0;
        sched_valid = 1'b0;
        last_exp    = 3'b000;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        compared++;
        assert (obs == expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        logic [2:0] e;
        logic [2:0] got;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e   = exp_q.pop_front();
            got = {keyon_II, kon_edge, koff_edge};
            assert (got === e) else begin
                mismatched++;
                $error("FAIL slot_out rot=%0d slot=%0d observed=%b expected=%b",
                       rot, slot_idx, got, e);
            end
        end
    endtask

    task automatic schedule(input int at_rot, input int ch, input logic [3:0] mask);
        sched_valid = 1'b1;
        sched_rot   = at_rot;
        sched_ch    = ch;
        sched_mask  = mask;
    endtask

    // One cen cycle presenting slot_idx (preceded by two gated cycles of
    // junk inputs when cen_stretch is set).
    task automatic tick(input logic up, input int ch, input logic [3:0] mask,
                        input logic ovf, input logic csm_i);
        logic       eff;
        logic [2:0] e;
        if (cen_stretch) begin
            for (int k = 0; k < 2; k++) begin
                cen        = 1'b0;
                up_keyon   = 1'b1;
                keyon_ch   = 3'($urandom_range(0, 7));
                keyon_op   = 4'($urandom_range(0, 15));
                cur_ch     = 3'($urandom_range(0, 7));
                cur_op     = 2'($urandom_range(0, 3));
                csm        = 1'($urandom_range(0, 1));
                overflow_A = 1'b0;
                exp_q.push_back(last_exp);
                @(posedge clk);
                #1;
                check_outputs();
            end
        end
        if (slot_idx == 0 && sched_valid && rot == sched_rot) begin
            for (int op = 0; op < OP; op++)
                intent[sched_ch * OP + op] = sched_mask[op_map[op]];
            sched_valid = 1'b0;
        end
        cen        = 1'b1;
        up_keyon   = up;
        keyon_ch   = 3'(ch);
        keyon_op   = mask;
        overflow_A = ovf;
        csm        = csm_i;
        cur_ch     = 3'(slot_idx / OP);
        cur_op     = 2'(slot_idx % OP);

        eff = intent[slot_idx] | (csm_left > 0);
        e   = {eff, eff & ~prev[slot_idx], ~eff & prev[slot_idx]};
        prev[slot_idx] = eff;
        if (ovf && csm_i)
            csm_left = SLOTS;
        else if (csm_left > 0)
            csm_left--;
        exp_q.push_back(e);
        last_exp = e;

        @(posedge clk);
        #1;
        check_outputs();
        if (busy === 1'b1)
            busy_cnt++;
        slot_idx++;
        if (slot_idx == SLOTS) begin
            slot_idx = 0;
            rot++;
        end
        up_keyon   = 1'b0;
        overflow_A = 1'b0;
        csm        = 1'b0;
    endtask

    task automatic idle_until(input int s);
        while (slot_idx != s)
            tick(1'b0, 0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic idle_rots(input int n);
        repeat (n * SLOTS)
            tick(1'b0, 0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        cen         = 1'b0;
        up_keyon    = 1'b0;
        keyon_op    = 4'h0;
        keyon_ch    = 3'd0;
        cur_ch      = 3'd0;
        cur_op      = 2'd0;
        csm         = 1'b0;
        overflow_A  = 1'b0;
        slot_idx    = 0;
        rot         = 0;
        busy_cnt    = 0;
        cen_stretch = 1'b0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_keyon_II", keyon_II, 1'b0);
        check_bit("rst_kon_edge", kon_edge, 1'b0);
        check_bit("rst_koff_edge", koff_edge, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        idle_rots(1);

        // CSM: overflow without csm is ignored, armed window, restart, csm=0 keeps it open
        idle_until(5);
        tick(1'b0, 0, 4'h0, 1'b1, 1'b0);
        idle_until(31);
        tick(1'b0, 0, 4'h0, 1'b1, 1'b1);
        idle_until(9);
        tick(1'b0, 0, 4'h0, 1'b1, 1'b1);
        idle_until(0);
        idle_rots(3);

        // full key-on of ch3 captured at the last slot
        busy_cnt = 0;
        idle_until(31);
        schedule(rot + 2, 3, 4'b1111);
        tick(1'b1, 3, 4'b1111, 1'b0, 1'b0);
        idle_rots(2);
        check_int("busy_len_ch3_on", busy_cnt, 16);
        idle_rots(1);

        // ch3 mask 0010 captured mid-visit (ch3 op1): waits for the next full visit
        busy_cnt = 0;
        idle_until(13);
        schedule(rot + 2, 3, 4'b0010);
        tick(1'b1, 3, 4'b0010, 1'b0, 1'b0);
        idle_until(0);
        idle_rots(2);
        check_int("busy_len_midvisit", busy_cnt, 34);

        // two requests one cycle apart: the second is dropped
        busy_cnt = 0;
        idle_until(30);
        schedule(rot + 2, 1, 4'b1111);
        tick(1'b1, 1, 4'b1111, 1'b0, 1'b0);
        tick(1'b1, 5, 4'b1111, 1'b0, 1'b0);
        idle_rots(2);
        check_int("busy_len_double", busy_cnt, 9);

        // cen active one cycle in three, gated cycles carry junk inputs
        cen_stretch = 1'b1;
        idle_until(31);
        schedule(rot + 2, 6, 4'b1111);
        tick(1'b1, 6, 4'b1111, 1'b0, 1'b0);
        idle_rots(2);
        cen_stretch = 1'b0;

        // reset while a ch2 request is pending, with cen low
        idle_until(31);
        tick(1'b1, 2, 4'b1111, 1'b0, 1'b0);
        idle_until(8);
        check_bit("pre_rst_busy", busy, 1'b1);
        check_bit("pre_rst_keyon_II", keyon_II, 1'b1);
        cen = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_bit("async_rst_busy", busy, 1'b0);
        check_bit("async_rst_keyon_II", keyon_II, 1'b0);
        check_bit("async_rst_kon_edge", kon_edge, 1'b0);
        check_bit("async_rst_koff_edge", koff_edge, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_until(0);
        idle_rots(1);

        // first request after reset is accepted normally
        busy_cnt = 0;
        idle_until(31);
        schedule(rot + 2, 2, 4'b1111);
        tick(1'b1, 2, 4'b1111, 1'b0, 1'b0);
        idle_rots(2);
        check_int("busy_len_after_rst", busy_cnt, 12);

        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
